// File: rtl/lc3b_mem_responder_pkg.sv
// lc3b_types: shared LC-3b word/mask types plus the memory responder state
// encoding. Imported by lc3b_mem_array and lc3b_mem_responder.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lc3b_memresp_state;

endpackage

// File: rtl/lc3b_mem_array.sv
// lc3b_mem_array: 2**ADDR_WIDTH x 16 storage with per-byte synchronous write
// and combinational read. Contents are not reset.
//   clk    in   write clock
//   we     in   byte write enables, bit0 = [7:0], bit1 = [15:8]
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  word at raddr (combinational)
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [15:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [15:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  lc3b_word mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we[0]) mem[waddr][7:0]  <= wdata[7:0];
    if (we[1]) mem[waddr][15:8] <= wdata[15:8];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: behavioural data memory for the LC-3b MEM stage.
// Accepts one request in IDLE, answers with a one-cycle mem_resp LATENCY
// cycles later, then returns to IDLE.
//   clk              in   system clock
//   reset_n          in   asynchronous active-low reset
//   mem_read         in   read request
//   mem_write        in   write request (wins over mem_read)
//   mem_address      in   byte address; [ADDR_WIDTH:1] selects the word
//   mem_wdata        in   write data
//   mem_byte_enable  in   byte write mask
//   mem_resp         out  completion pulse
//   mem_rdata        out  read data, valid with mem_resp
//   mem_proto_err    out  read and write raised together at acceptance
//
// state | meaning
// IDLE  | waiting for a request; captures it on acceptance
// WAIT  | counting down remaining latency
// RESP  | mem_resp high; a captured write commits on the exit edge
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        mem_proto_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("lc3b_mem_responder: LATENCY must be within 1..15");
  end

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lc3b_memresp_state state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic [ADDR_WIDTH-1:0] cap_idx;
  lc3b_word              cap_wdata;
  lc3b_mem_wmask         cap_be;
  logic                  cap_write;
  lc3b_word              rdata_q;

  logic [ADDR_WIDTH-1:0] in_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  accept;
  logic                  rd_op;
  logic                  load_rdata;
  lc3b_mem_wmask         arr_we;
  lc3b_word              arr_rdata;

  // Only the word-index bits select storage; the byte bit and the upper
  // bits are dropped so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[0], mem_address >> (ADDR_WIDTH + 1)};

  assign in_idx = mem_address[ADDR_WIDTH:1];
  assign accept = (state == IDLE) && (mem_read || mem_write);

  // With LATENCY==1 RESP is entered on the acceptance edge, before the
  // capture registers hold the request, so the read path looks at the
  // live inputs while in IDLE.
  assign rd_idx = (state == IDLE) ? in_idx : cap_idx;
  assign rd_op  = (state == IDLE) ? (mem_read && !mem_write) : !cap_write;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_ONE) state_nxt = RESP;
        if (cnt != '0)      cnt_nxt   = cnt - CNT_ONE;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign load_rdata = (state_nxt == RESP) && rd_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      cap_write <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_idx   <= in_idx;
        cap_wdata <= mem_wdata;
        cap_be    <= mem_byte_enable;
        cap_write <= mem_write;
      end
      if (load_rdata) rdata_q <= arr_rdata;
    end
  end

  // The write lands on the RESP->IDLE edge, so a request accepted right
  // after sees the updated word.
  assign arr_we = (state == RESP && cap_write) ? cap_be : 2'b00;

  lc3b_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (cap_idx),
    .wdata (cap_wdata),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  assign mem_resp      = (state == RESP);
  assign mem_rdata     = rdata_q;
  assign mem_proto_err = (state == IDLE) && mem_read && mem_write;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
module tb_lc3b_mem_responder;

  localparam int AW  = 10;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        mem_proto_err;

  int checks = 0;
  int errors = 0;

  // Reference model: plain word array indexed by the aliased word index.
  logic [15:0] ref_mem [2**AW];
  bit          known   [2**AW];
  logic [15:0] exp_rdata;

  always #5 clk = ~clk;

  lc3b_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .mem_proto_err   (mem_proto_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return int'(a[AW:1]);
  endfunction

  task automatic drop_req();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Starts in the current cycle (cycle 0) and returns in cycle LAT+1.
  // hold = number of cycles the request stays high.
  task automatic txn(input bit rd, input bit wr, input logic [15:0] addr,
                     input logic [15:0] wd, input logic [1:0] be, input int hold,
                     input string tag);
    int idx;
    idx = widx(addr);
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_wdata = wd; mem_byte_enable = be;
    #1;
    chk({tag, "_proto_c0"}, 16'(mem_proto_err), 16'(rd & wr));
    chk({tag, "_resp_c0"}, 16'(mem_resp), 16'h0);
    if (!wr) exp_rdata = ref_mem[idx];
    for (int c = 1; c <= LAT + 1; c++) begin
      @(posedge clk); #1;
      if (c >= hold) drop_req();
      #1;
      chk($sformatf("%s_resp_c%0d", tag, c), 16'(mem_resp), 16'(c == LAT));
      if (c == LAT) chk({tag, "_rdata"}, mem_rdata, exp_rdata);
    end
    if (wr) begin
      if (be[0]) ref_mem[idx][7:0]  = wd[7:0];
      if (be[1]) ref_mem[idx][15:8] = wd[15:8];
      if (be != 2'b00) known[idx] = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] a, d;
    logic [1:0]  be;
    int          op, idx;
    logic [15:0] pool [8];

    reset_n = 1'b0;
    drop_req();
    mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
    exp_rdata = '0;
    for (int i = 0; i < 2**AW; i++) known[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp", 16'(mem_resp), 16'h0);
    chk("rst_rdata", mem_rdata, 16'h0000);
    chk("rst_proto", 16'(mem_proto_err), 16'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #2;

    // Preload word 0x010 and read it back.
    txn(0, 1, 16'h0020, 16'hBEEF, 2'b11, 1, "preload");
    txn(1, 0, 16'h0020, 16'h0000, 2'b00, 1, "rd_beef");
    chk("beef_model", exp_rdata, 16'hBEEF);

    // Byte enables.
    txn(0, 1, 16'h0020, 16'h1234, 2'b10, 1, "wr_hi");
    txn(1, 0, 16'h0020, 16'h0000, 2'b11, 1, "rd_12ef");
    chk("12ef_model", exp_rdata, 16'h12EF);
    txn(0, 1, 16'h0020, 16'hFFFF, 2'b00, 1, "wr_be0");
    txn(1, 0, 16'h0021, 16'h0000, 2'b01, 1, "rd_after_be0");
    chk("be0_model", exp_rdata, 16'h12EF);
    txn(0, 1, 16'h0030, 16'hCD00, 2'b11, 1, "wr_30");
    txn(0, 1, 16'h0030, 16'h11AB, 2'b01, 1, "wr_lo");
    txn(1, 0, 16'h0030, 16'h0000, 2'b00, 1, "rd_cdab");
    chk("cdab_model", exp_rdata, 16'hCDAB);

    // Continuous read: responses in cycles 3 and 7 only.
    txn(0, 1, 16'h0002, 16'h3C3C, 2'b11, 1, "wr_02");
    mem_read = 1'b1; mem_address = 16'h0002; mem_byte_enable = 2'b00;
    exp_rdata = 16'h3C3C;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 8) drop_req();
      #1;
      chk($sformatf("hold_resp_c%0d", c), 16'(mem_resp), 16'(c == 3 || c == 7));
      if (c == 3 || c == 7) chk($sformatf("hold_rdata_c%0d", c), mem_rdata, exp_rdata);
    end

    // Request dropped in cycle 1 still completes and commits.
    txn(0, 1, 16'h0040, 16'hA5A5, 2'b11, 1, "wr_drop");
    txn(1, 0, 16'h0040, 16'h0000, 2'b00, 1, "rd_a5a5");
    chk("a5a5_model", exp_rdata, 16'hA5A5);

    // Reset in cycle 2 of a write aborts it.
    mem_write = 1'b1; mem_address = 16'h0040; mem_wdata = 16'h5A5A; mem_byte_enable = 2'b11;
    @(posedge clk); #1; drop_req();
    @(posedge clk); #1; reset_n = 1'b0; #1;
    chk("abort_resp", 16'(mem_resp), 16'h0);
    chk("abort_rdata", mem_rdata, 16'h0000);
    chk("abort_proto", 16'(mem_proto_err), 16'h0);
    for (int c = 3; c <= 5; c++) begin
      @(posedge clk); #2;
      chk($sformatf("abort_resp_c%0d", c), 16'(mem_resp), 16'h0);
    end
    exp_rdata = 16'h0000;
    reset_n = 1'b1;
    @(posedge clk); #2;
    txn(1, 0, 16'h0040, 16'h0000, 2'b00, 1, "rd_after_abort");
    chk("abort_model", exp_rdata, 16'hA5A5);

    // Read and write together: write wins, rdata holds.
    txn(1, 1, 16'h0060, 16'h0F0F, 2'b11, 1, "proto");
    chk("proto_hold_model", exp_rdata, 16'hA5A5);
    txn(1, 0, 16'h0060, 16'h0000, 2'b00, 1, "rd_0f0f");
    chk("0f0f_model", exp_rdata, 16'h0F0F);

    // Aliasing above the word-index bits.
    txn(0, 1, 16'h0804, 16'h7777, 2'b11, 1, "wr_alias");
    txn(1, 0, 16'h0004, 16'h0000, 2'b00, 1, "rd_alias");
    chk("alias_model", exp_rdata, 16'h7777);

    // Randomized mix against the model.
    for (int i = 0; i < 8; i++) pool[i] = 16'($urandom_range(0, 2**AW - 1)) << 1;
    for (int n = 0; n < 60; n++) begin
      a = pool[$urandom_range(0, 7)];
      a[15:AW+1] = 5'($urandom);
      a[0] = 1'($urandom);
      d  = 16'($urandom);
      be = 2'($urandom);
      op = $urandom_range(0, 3);
      idx = widx(a);
      if (op < 2 && !known[idx]) op = 2;
      if (op >= 2 && !known[idx]) be = 2'b11;
      case (op)
        0, 1:    txn(1, 0, a, d, be, $urandom_range(1, LAT), $sformatf("rnd%0d_rd", n));
        2:       txn(0, 1, a, d, be, $urandom_range(1, LAT), $sformatf("rnd%0d_wr", n));
        default: txn(1, 1, a, d, be, 1, $sformatf("rnd%0d_rw", n));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
